// File: rtl/izh_pkg.sv
// Shared widths, Q8.8 Izhikevich coefficients, sequencer state encoding and
// the saturating narrowing helper used by the update datapath.
package izh_pkg;

    localparam int NUMWIDTH   = 16;
    localparam int NUMNEURONS = 2;
    localparam int TAGBITS    = 1;
    localparam int PW         = 40;

    localparam int K2     = 10;
    localparam int K1     = 1280;
    localparam int K0     = 35840;
    localparam int A      = 5;
    localparam int B      = 51;
    localparam int C      = -16640;
    localparam int D      = 2048;
    localparam int V_PEAK = 7680;

    typedef logic signed [NUMWIDTH:0] word_t;
    typedef logic signed [PW-1:0]     wide_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_CALC  = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    localparam wide_t WORD_MAX = wide_t'((64'sd1 <<< NUMWIDTH) - 64'sd1);
    localparam wide_t WORD_MIN = wide_t'(-(64'sd1 <<< NUMWIDTH));

    // Clamp a wide intermediate into the signed state word range.
    function automatic word_t sat(input wide_t x);
        wide_t y;
        y = x;
        if (x > WORD_MAX) y = WORD_MAX;
        if (x < WORD_MIN) y = WORD_MIN;
        return y[NUMWIDTH:0];
    endfunction

endpackage

// File: rtl/izh_datapath.sv
// One Euler step of the Izhikevich model in Q8.8, including the spike
// substitution of v and u; purely combinational.
module izh_datapath
    import izh_pkg::*;
(
    input  logic signed [NUMWIDTH:0] v_i,
    input  logic signed [NUMWIDTH:0] u_i,
    input  logic signed [NUMWIDTH:0] i_in_i,
    output logic signed [NUMWIDTH:0] vn_o,
    output logic signed [NUMWIDTH:0] un_o,
    output logic                     fire_o
);

    localparam wide_t K2_W = wide_t'(K2);
    localparam wide_t K1_W = wide_t'(K1);
    localparam wide_t K0_W = wide_t'(K0);
    localparam wide_t A_W  = wide_t'(A);
    localparam wide_t B_W  = wide_t'(B);
    localparam wide_t D_W  = wide_t'(D);
    localparam word_t C_WORD    = word_t'(C);
    localparam word_t PEAK_WORD = word_t'(V_PEAK);

    wide_t v_w, u_w, i_w;
    wide_t sq, dv, du;
    word_t vn, un, un_spk;

    assign v_w = {{(PW-NUMWIDTH-1){v_i[NUMWIDTH]}}, v_i};
    assign u_w = {{(PW-NUMWIDTH-1){u_i[NUMWIDTH]}}, u_i};
    assign i_w = {{(PW-NUMWIDTH-1){i_in_i[NUMWIDTH]}}, i_in_i};

    // Every shift is arithmetic, so fractional parts round toward minus infinity.
    assign sq = (v_w * v_w) >>> 8;
    assign dv = ((K2_W * sq) >>> 8) + ((K1_W * v_w) >>> 8) + K0_W - u_w + i_w;
    assign du = (A_W * (((B_W * v_w) >>> 8) - u_w)) >>> 8;

    assign vn     = sat(v_w + dv);
    assign un     = sat(u_w + du);
    assign un_spk = sat({{(PW-NUMWIDTH-1){un[NUMWIDTH]}}, un} + D_W);

    assign fire_o = (vn >= PEAK_WORD);
    assign vn_o   = fire_o ? C_WORD : vn;
    assign un_o   = fire_o ? un_spk : un;

endmodule

// File: rtl/izh_update_engine.sv
// Timestep sweep sequencer: READ/CALC/WRITE per neuron tag against the state
// register, with spike flagging on the write of a firing neuron.
module izh_update_engine
    import izh_pkg::*;
(
    input  logic                     clk,
    input  logic                     syn_reset,
    input  logic                     step,
    input  logic signed [NUMWIDTH:0] i_in,
    input  logic signed [NUMWIDTH:0] sr_v,
    input  logic signed [NUMWIDTH:0] sr_u,
    output logic                     sr_read,
    output logic                     sr_write,
    output logic [TAGBITS-1:0]       sr_tag,
    output logic signed [NUMWIDTH:0] sr_v_new,
    output logic signed [NUMWIDTH:0] sr_u_new,
    output logic                     busy,
    output logic                     done,
    output logic                     spike,
    output logic [TAGBITS-1:0]       spike_tag
);

    localparam logic [TAGBITS-1:0] LAST_TAG = TAGBITS'(NUMNEURONS - 1);

    state_t             state_q, state_d;
    logic [TAGBITS-1:0] cnt_q, cnt_d;
    word_t              v_new_q, u_new_q;
    logic               fire_q;

    word_t vn, un;
    logic  fire;

    izh_datapath u_datapath (
        .v_i    (sr_v),
        .u_i    (sr_u),
        .i_in_i (i_in),
        .vn_o   (vn),
        .un_o   (un),
        .fire_o (fire)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (step) begin
                    cnt_d   = '0;
                    state_d = ST_READ;
                end
            end
            ST_READ:  state_d = ST_CALC;
            ST_CALC:  state_d = ST_WRITE;
            ST_WRITE: begin
                if (cnt_q == LAST_TAG) begin
                    state_d = ST_DONE;
                end else begin
                    cnt_d   = cnt_q + TAGBITS'(1);
                    state_d = ST_READ;
                end
            end
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (syn_reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            v_new_q <= '0;
            u_new_q <= '0;
            fire_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            // Read data arrives the cycle after READ, so capture it in CALC.
            if (state_q == ST_CALC) begin
                v_new_q <= vn;
                u_new_q <= un;
                fire_q  <= fire;
            end
        end
    end

    assign sr_read   = (state_q == ST_READ);
    assign sr_write  = (state_q == ST_WRITE);
    assign sr_tag    = cnt_q;
    assign sr_v_new  = v_new_q;
    assign sr_u_new  = u_new_q;
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);
    assign spike     = (state_q == ST_WRITE) && fire_q;
    assign spike_tag = spike ? cnt_q : '0;

endmodule

// File: doc/izh_update_engine.md
# izh_update_engine

Per-timestep sequencer that drives the neuron state register as its read/write client. On each `step` pulse it walks every neuron tag in order. For each tag it reads (v, u), applies one Izhikevich Euler update in Q8.8 fixed point, and writes the result back. It flags a spike and tags it when v crosses the peak. It sits between the timestep controller and the state register; spike outputs feed the downstream spike router.

## Interface
- numwidth, 16: MSB index of state words; words are [numwidth:0] (1 sign + 8 int + 8 frac), signed.
- numneurons, 2: neurons per timestep; power of two.
- tagbits, 1: log2(numneurons).
- K2, 10: 0.04 in Q8.8.
- K1, 1280: 5.0.
- K0, 35840: 140.0.
- A, 5: 0.02.
- B, 51: 0.2.
- C, -16640: -65.0 reset potential.
- D, 2048: 8.0 recovery increment.
- V_PEAK, 7680: 30.0 spike threshold.

Ports:
- clk  in  1  clock; all logic on posedge.
- syn_reset  in  1  synchronous, active-high reset.
- step  in  1  start one timestep sweep; honoured only in IDLE.
- i_in  in  numwidth+1  input current for the tag currently in CALC, signed Q8.8.
- sr_v, sr_u  in  numwidth+1 each  state register read data; valid the cycle after sr_read.
- sr_read  out  1  read strobe to state register.
- sr_write  out  1  write strobe to state register.
- sr_tag  out  tagbits  neuron address.
- sr_v_new, sr_u_new  out  numwidth+1 each  write data.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at sweep end.
- spike  out  1  one-cycle pulse, WRITE cycle of a spiking neuron.
- spike_tag  out  tagbits  tag of the spiking neuron; valid with spike.

## Operation
- States: IDLE, READ, CALC, WRITE, DONE.
- IDLE: when step=1, clear tag counter and go to READ.
- READ: sr_read=1, sr_tag=cnt. Go to CALC.
- CALC: sample sr_v, sr_u and i_in. Compute the update and register the results into sr_v_new and sr_u_new. Go to WRITE.
- WRITE: sr_write=1, sr_tag=cnt. Then:
  - if cnt == numneurons-1, go to DONE;
  - otherwise increment cnt and go to READ.
- DONE: done=1. Go to IDLE.
- sr_read and sr_write are never high in the same cycle. The state register prioritises read, so overlap would drop the write.
- Arithmetic: all products are signed, at least 40 bits wide. `>>>` is an arithmetic shift (floor). sat() clamps to [-65536, 65535].
  - sq = (v*v)>>>8
  - dv = ((K2*sq)>>>8) + ((K1*v)>>>8) + K0 - u + i_in
  - vn = sat(v + dv)
  - du = (A*(((B*v)>>>8) - u))>>>8
  - un = sat(u + du)
- Spike: if vn >= V_PEAK, write v = C and u = sat(un + D), and pulse spike with spike_tag = cnt in WRITE. Otherwise write vn and un.
- step while busy is ignored; it is not queued.

## Timing
- Reset values:
  - state = IDLE, cnt = 0.
  - sr_read, sr_write, busy, done, spike = 0.
  - sr_tag, spike_tag = 0.
  - sr_v_new, sr_u_new = 0.
- Control outputs (sr_read, sr_write, sr_tag, busy, done, spike, spike_tag) are Moore-decoded from state and counter.
- With step high in cycle t (state IDLE):
  - READ tag k in cycle t+1+3k;
  - CALC tag k in t+2+3k;
  - WRITE tag k in t+3+3k;
  - done in t+3N+1, where N = numneurons;
  - back in IDLE at t+3N+2, where a new step may be accepted.
- Sweep latency is 3N+1 cycles, with busy high for all of them.
- Read data latency is fixed at one cycle (state register registered output); no handshake.
- syn_reset mid-sweep returns to IDLE the next edge with all outputs zero.
  - A write in progress is abandoned; state register contents are not touched by this block.
- If syn_reset and step are high together, reset wins.

## Structure
- Shared package `izh_pkg`: numwidth, tagbits, Q8.8 coefficient constants (K2, K1, K0, A, B, C, D, V_PEAK), the state enum, and the sat() function.
- One combinational sub-module `izh_datapath` (v, u, i_in → vn, un, fire). The FSM in `izh_update_engine` registers its outputs in CALC.

## Test plan
- Reset: hold syn_reset 2 cycles with step=1 → all outputs 0, state IDLE, no sr_read.
- Rest update: v=-16640, u=-3328, i_in=0 → sr_v_new=-18422, sr_u_new=-3328, spike=0.
- Spike: v=7680, u=0, i_in=0 → vn saturates to 65535 and fires; sr_v_new=-16640, sr_u_new=2077, spike=1, spike_tag=cnt.
- Sweep timing, N=2: step at t → sr_read at t+1 and t+4, sr_write at t+3 and t+6, done at t+7, busy high t+1..t+7; sr_read and sr_write never overlap.
- Ignored step: pulse step at t+2 during a sweep → no extra READ; sweep ends at t+7 as normal.
- Mid-sweep reset: syn_reset at t+3 (WRITE tag 0) → IDLE at t+4, sr_write=0, done never pulses; a fresh step restarts at tag 0.
